b08_drv: RTL and testbench
==========================

B08_DRV -- requirements
Module: b08_drv

Interface
REQ-001 Parameter WAIT_CYC, default 18: the number of cycles from the end of HOLD to the edge that captures the result; minimum 17.
REQ-002 Port CLOCK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port RESET_N, input, 1: asynchronous active-low reset.
REQ-004 Port GO, input, 1: request to start a burst of transactions; sampled only in IDLE.
REQ-005 Port SEED, input, 8: LFSR seed loaded when GO is accepted.
REQ-006 Port NTX, input, 4: number of transactions per burst; the value 0 SHALL mean 16.
REQ-007 Port O, input, 4: result code returned by the pattern-match responder.
REQ-008 Port START, output, 1: start strobe to the responder.
REQ-009 Port I, output, 8: data byte to the responder.
REQ-010 Port BUSY, output, 1: high in every state except IDLE.
REQ-011 Port DONE, output, 1: one-cycle pulse at the end of a burst.
REQ-012 Port RESULT, output, 4: the most recently captured O.
REQ-013 Port OR_ACC, output, 4: bitwise OR of all O values captured in the current burst.
REQ-014 Port NOMATCH_CNT, output, 4: count of captures with O==0, saturating at 15.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, HOLD and WAIT.
REQ-016 IDLE with GO=1 at an edge SHALL:
- load the LFSR with SEED, substituting 8'h01 when SEED==0;
- load the remaining-transaction count with NTX, with 0 meaning 16;
- clear OR_ACC and NOMATCH_CNT;
- move to REQ.
REQ-017 IDLE with GO=0 SHALL stay in IDLE.
REQ-018 In REQ, START SHALL be 1 and I SHALL equal the LFSR value, for exactly one cycle; the FSM then goes to HOLD.
REQ-019 In HOLD, START SHALL be 0 and I SHALL remain unchanged; the FSM then goes to WAIT with the timer loaded to WAIT_CYC.
REQ-020 In WAIT, START SHALL be 0, I SHALL be held, and the timer SHALL decrement once per cycle.
REQ-021 On the edge where the timer reaches 1 (the capture edge), the block SHALL perform all of the following in that same edge:
- RESULT<=O;
- OR_ACC<=OR_ACC|O;
- increment NOMATCH_CNT, saturating, if O==0;
- advance the LFSR;
- decrement the remaining-transaction count.
REQ-022 LFSR advance SHALL be next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-023 At the capture edge, if the remaining count was 1, the FSM SHALL go to IDLE and assert DONE for the following cycle only; otherwise it SHALL go to REQ.
REQ-024 Timing: with GO accepted at edge g, START SHALL be high between edges g and g+1, the capture edge SHALL be g+2+WAIT_CYC, and successive START pulses SHALL be 2+WAIT_CYC cycles apart.
REQ-025 GO SHALL be ignored while BUSY=1.
REQ-026 GO asserted in the DONE cycle SHALL be accepted, because that cycle is IDLE.
REQ-027 O SHALL be sampled only at capture edges; changes on O at all other times SHALL have no effect.
REQ-028 START SHALL never be high in two consecutive cycles.
REQ-029 I SHALL change only on the edge that enters REQ.

Reset
REQ-030 While RESET_N=0, all of the following SHALL be forced immediately, independent of CLOCK:
- state=IDLE;
- START, I, BUSY, DONE, RESULT, OR_ACC and NOMATCH_CNT = 0;
- LFSR=8'h01;
- timer and remaining count = 0.
REQ-031 Reset asserted in any state, including mid-WAIT, SHALL abort the burst with no DONE pulse.
REQ-032 After RESET_N deasserts, the first GO SHALL start a clean burst.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- RESET_N low at time 0 with CLOCK stopped -> all outputs 0 before the first edge.
- SEED=0x00, NTX=1, GO at edge g, O model=4'h3 -> START=1 only in cycle g..g+1 with I=0x01; I=0x01 held through capture edge g+20; DONE high g+20..g+21; RESULT=3; OR_ACC=3; BUSY low from g+20.
- SEED=0x01, NTX=3, O=4'h5 constant -> START pulses at g, g+20, g+40 carrying I=0x01, 0x02, 0x04; OR_ACC=5; NOMATCH_CNT=0.
- SEED=0x08, NTX=2, O=4'h1 then 4'h8 -> bytes 0x08, 0x11; OR_ACC=9; RESULT=8.
- NTX=0, O=0 -> 16 START pulses; NOMATCH_CNT=15 (saturated); OR_ACC=0; a single DONE.
- GO pulsed during WAIT -> ignored; then RESET_N low mid-WAIT -> START/I/BUSY=0 asynchronously; no DONE; a subsequent GO with SEED=0 -> I=0x01.

Source files
------------

// File: rtl/b08_drv.sv
// rtl/b08_drv.sv - burst driver: LFSR bytes to a pattern-match responder, captures its result code
module b08_drv #(
   parameter int WAIT_CYC = 18
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       GO,
   input  logic [7:0] SEED,
   input  logic [3:0] NTX,
   input  logic [3:0] O,
   output logic       START,
   output logic [7:0] I,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] RESULT,
   output logic [3:0] OR_ACC,
   output logic [3:0] NOMATCH_CNT
);

   localparam int TW = $clog2(WAIT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_lfsr;
   logic [7:0]    r_i;
   logic [TW-1:0] r_timer;
   logic [4:0]    r_remain;
   logic          r_done;
   logic [3:0]    r_result;
   logic [3:0]    r_or_acc;
   logic [3:0]    r_nomatch;

   logic          w_go;
   logic          w_capture;
   logic          w_last;
   logic [7:0]    w_seed;
   logic [7:0]    w_lfsr_next;

   assign w_go        = (r_state == S_IDLE) && GO;
   assign w_capture   = (r_state == S_WAIT) && (r_timer == TW'(1));
   assign w_last      = (r_remain == 5'd1);
   assign w_seed      = (SEED == 8'h00) ? 8'h01 : SEED;
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (GO) w_next = S_REQ;
         S_REQ:  w_next = S_HOLD;
         S_HOLD: w_next = S_WAIT;
         S_WAIT: if (w_capture) w_next = w_last ? S_IDLE : S_REQ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_lfsr    <= 8'h01;
         r_i       <= 8'h00;
         r_timer   <= '0;
         r_remain  <= 5'd0;
         r_done    <= 1'b0;
         r_result  <= 4'h0;
         r_or_acc  <= 4'h0;
         r_nomatch <= 4'h0;
      end else begin
         r_done <= w_capture && w_last;
         if (w_go) begin
            r_lfsr    <= w_seed;
            r_i       <= w_seed;
            r_remain  <= (NTX == 4'h0) ? 5'd16 : {1'b0, NTX};
            r_or_acc  <= 4'h0;
            r_nomatch <= 4'h0;
         end
         if (r_state == S_HOLD) begin
            r_timer <= TW'(WAIT_CYC);
         end else if (r_state == S_WAIT) begin
            r_timer <= r_timer - TW'(1);
         end
         if (w_capture) begin
            r_result <= O;
            r_or_acc <= r_or_acc | O;
            if ((O == 4'h0) && (r_nomatch != 4'hF)) r_nomatch <= r_nomatch + 4'h1;
            r_lfsr   <= w_lfsr_next;
            r_remain <= r_remain - 5'd1;
            // I only moves when another REQ follows; the final advance stays internal
            if (!w_last) r_i <= w_lfsr_next;
         end
      end
   end

   assign START       = (r_state == S_REQ);
   assign BUSY        = (r_state != S_IDLE);
   assign I           = r_i;
   assign DONE        = r_done;
   assign RESULT      = r_result;
   assign OR_ACC      = r_or_acc;
   assign NOMATCH_CNT = r_nomatch;

endmodule

// File: tb/tb_b08_drv.sv
// tb/tb_b08_drv.sv - scoreboard bench for b08_drv: directed bursts, GO-while-busy and mid-WAIT reset
module tb_b08_drv;

   localparam int W = 18;

   logic       CLOCK;
   logic       RESET_N;
   logic       GO;
   logic [7:0] SEED;
   logic [3:0] NTX;
   logic [3:0] O = 4'h0;
   logic       START;
   logic [7:0] I;
   logic       BUSY;
   logic       DONE;
   logic [3:0] RESULT;
   logic [3:0] OR_ACC;
   logic [3:0] NOMATCH_CNT;

   b08_drv #(.WAIT_CYC(W)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .GO(GO), .SEED(SEED), .NTX(NTX), .O(O),
      .START(START), .I(I), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
      .OR_ACC(OR_ACC), .NOMATCH_CNT(NOMATCH_CNT)
   );

   typedef struct {int cyc; logic [7:0] i;} start_t;
   typedef struct {int cyc; logic [3:0] res; logic [3:0] acc; logic [3:0] nm;} done_t;

   start_t     sq[$];
   done_t      dq[$];
   logic [3:0] oq[$];
   logic [7:0] exp_bytes[$];
   logic [3:0] exp_os[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 0;

   start_t     s_pop;
   done_t      d_pop;
   logic [3:0] o_cur   = 4'h0;
   int         cap_cyc = -100;
   logic       prev_start = 1'b0;
   logic [7:0] prev_i = 8'h00;

   initial begin
      CLOCK = 1'b0;
      #20;
      forever #5 CLOCK = ~CLOCK;
   end

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Monitor: pops expectations on START / DONE and drives O only around each capture edge
   always @(negedge CLOCK) begin
      if (mon_en) begin
         chk("start_not_consecutive", int'(prev_start && START), 0);
         if (!START) chk("i_stable", I, prev_i);
         if (START) begin
            if (sq.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               s_pop = sq.pop_front();
               chk("start_cycle", cyc, s_pop.cyc);
               chk("start_i", I, s_pop.i);
               chk("busy_in_req", BUSY, 1);
            end
            o_cur   = (oq.size() != 0) ? oq.pop_front() : 4'h0;
            cap_cyc = cyc + 2 + W;
         end
         if (DONE) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               d_pop = dq.pop_front();
               chk("done_cycle", cyc, d_pop.cyc);
               chk("result", RESULT, d_pop.res);
               chk("or_acc", OR_ACC, d_pop.acc);
               chk("nomatch_cnt", NOMATCH_CNT, d_pop.nm);
               chk("busy_at_done", BUSY, 0);
            end
         end
         if (cyc == cap_cyc - 1) O = o_cur;
         else                    O = ~o_cur;
      end
      prev_start = START;
      prev_i     = I;
   end

   task automatic burst(input logic [7:0] seed, input logic [3:0] ntx, input bit chain,
                        input logic [3:0] res, input logic [3:0] acc, input logic [3:0] nm);
      int     n;
      int     g;
      start_t s;
      done_t  d;
      n = (ntx == 4'h0) ? 16 : int'(ntx);
      if (chain) begin
         for (int k = 0; k < 200; k++) begin
            @(negedge CLOCK);
            if (DONE) break;
         end
         chk("chain_done_seen", DONE, 1);
      end else begin
         @(negedge CLOCK);
      end
      g = cyc + 1;
      for (int k = 0; k < n; k++) begin
         s.cyc = g + k * (2 + W);
         s.i   = exp_bytes[k];
         sq.push_back(s);
         oq.push_back(exp_os[k]);
      end
      d.cyc = g + n * (2 + W);
      d.res = res;
      d.acc = acc;
      d.nm  = nm;
      dq.push_back(d);
      GO   = 1'b1;
      SEED = seed;
      NTX  = ntx;
      @(negedge CLOCK);
      GO   = 1'b0;
      SEED = 8'hA7;
      NTX  = 4'h6;
      exp_bytes.delete();
      exp_os.delete();
   endtask

   task automatic wait_idle(input int bound);
      for (int k = 0; k < bound; k++) begin
         if (sq.size() == 0 && dq.size() == 0) break;
         @(negedge CLOCK);
      end
      chk("drain_pending", sq.size() + dq.size(), 0);
      @(negedge CLOCK);
   endtask

   initial begin
      logic [7:0] v;
      RESET_N = 1'b0;
      GO      = 1'b0;
      SEED    = 8'h00;
      NTX     = 4'h0;
      #5;
      chk("rst_start", START, 0);
      chk("rst_i", I, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_result", RESULT, 0);
      chk("rst_or_acc", OR_ACC, 0);
      chk("rst_nomatch", NOMATCH_CNT, 0);
      @(negedge CLOCK);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      mon_en  = 1'b1;

      // SEED=0 substitutes 0x01, single transaction
      exp_bytes = '{8'h01};
      exp_os    = '{4'h3};
      burst(8'h00, 4'h1, 1'b0, 4'h3, 4'h3, 4'h0);
      wait_idle(100);

      // three transactions, then a GO landing in the DONE cycle
      exp_bytes = '{8'h01, 8'h02, 8'h04};
      exp_os    = '{4'h5, 4'h5, 4'h5};
      burst(8'h01, 4'h3, 1'b0, 4'h5, 4'h5, 4'h0);
      exp_bytes = '{8'h08, 8'h11};
      exp_os    = '{4'h1, 4'h8};
      burst(8'h08, 4'h2, 1'b1, 4'h8, 4'h9, 4'h0);
      wait_idle(200);

      // NTX=0 means sixteen; NOMATCH_CNT saturates at 15
      v = 8'h01;
      for (int k = 0; k < 16; k++) begin
         exp_bytes.push_back(v);
         exp_os.push_back(4'h0);
         v = lfsr_step(v);
      end
      burst(8'h01, 4'h0, 1'b0, 4'h0, 4'h0, 4'hF);
      wait_idle(500);

      // GO while busy is ignored, then an asynchronous reset mid-WAIT aborts the burst
      exp_bytes = '{8'h01, 8'h02};
      exp_os    = '{4'h2, 4'h2};
      burst(8'h01, 4'h2, 1'b0, 4'h2, 4'h2, 4'h0);
      repeat (5) @(negedge CLOCK);
      GO   = 1'b1;
      SEED = 8'h55;
      NTX  = 4'h1;
      @(negedge CLOCK);
      GO   = 1'b0;
      repeat (2) @(negedge CLOCK);
      chk("first_start_seen", sq.size(), 1);
      chk("busy_mid_wait", BUSY, 1);
      mon_en = 1'b0;
      #2;
      RESET_N = 1'b0;
      #1;
      chk("async_rst_start", START, 0);
      chk("async_rst_i", I, 0);
      chk("async_rst_busy", BUSY, 0);
      chk("async_rst_done", DONE, 0);
      chk("async_rst_or_acc", OR_ACC, 0);
      sq.delete();
      dq.delete();
      oq.delete();
      repeat (2) @(negedge CLOCK);
      RESET_N = 1'b1;
      mon_en  = 1'b1;
      repeat (45) @(negedge CLOCK);
      chk("idle_after_abort", BUSY, 0);

      exp_bytes = '{8'h01};
      exp_os    = '{4'h6};
      burst(8'h00, 4'h1, 1'b0, 4'h6, 4'h6, 4'h0);
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
